// File: rtl/hsv_pkg.sv
// Shared types and field widths for the pixel-to-HSV scheduling path.
package hsv_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StEmit
    } state_t;

    localparam int unsigned RGB_W  = 5;
    localparam int unsigned PIX_W  = 1 + 3 * RGB_W;
    localparam int unsigned FIFO_W = PIX_W + 1;
    localparam int unsigned HUE_W  = 7;
    localparam int unsigned SAT_W  = 5;
    localparam int unsigned VAL_W  = 5;
    localparam int unsigned TCNT_W = 8;

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO for incoming pixels; head entry is visible combinationally on rd_data.
module pix_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hsv_pixel_sched.sv
// Feeds buffered RGB555 pixels one at a time through a shared rgb2hsv converter and emits
// the HSV result with its frame coordinates, abandoning conversions that never complete.
module hsv_pixel_sched
    import hsv_pkg::*;
#(
    parameter int unsigned WIDTH        = 320,
    parameter int unsigned HEIGHT       = 240,
    parameter int unsigned XW           = 9,
    parameter int unsigned YW           = 8,
    parameter int unsigned CONV_TIMEOUT = 32,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              res,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic              conv_read,
    output logic [PIX_W-1:0]  conv_data,
    input  logic              conv_done,
    input  logic [HUE_W-1:0]  conv_hue,
    input  logic              conv_hue_invalid,
    input  logic [SAT_W-1:0]  conv_sat,
    input  logic [VAL_W-1:0]  conv_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HUE_W-1:0]  out_hue,
    output logic [SAT_W-1:0]  out_sat,
    output logic [VAL_W-1:0]  out_val,
    output logic              out_hue_inv,
    output logic [XW-1:0]     out_x,
    output logic [YW-1:0]     out_y,
    output logic [TCNT_W-1:0] timeout_cnt
);

    localparam int unsigned   TW         = (CONV_TIMEOUT > 2) ? $clog2(CONV_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CONV_TIMEOUT - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(HEIGHT - 1);

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic              sof_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;

    logic              fifo_wr;
    logic              fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_head;

    assign pix_ready = !fifo_full;
    assign fifo_wr   = pix_valid && pix_ready;
    assign fifo_rd   = (state_q == StIssue);
    assign conv_read = (state_q == StIssue);
    assign conv_data = conv_read ? fifo_head[PIX_W-1:0] : '0;

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .res     (res),
        .wr_en   (fifo_wr),
        .wr_data ({pix_sof, pix_data}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            sof_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            out_valid   <= 1'b0;
            out_hue     <= '0;
            out_sat     <= '0;
            out_val     <= '0;
            out_hue_inv <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            timeout_cnt <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    sof_q   <= fifo_head[FIFO_W-1];
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (conv_done || (timer_q == TIMER_LAST)) begin
                        out_valid <= 1'b1;
                        out_x     <= sof_q ? '0 : x_q;
                        out_y     <= sof_q ? '0 : y_q;
                        state_q   <= StEmit;
                        // A done arriving on the last timer cycle still counts as a result.
                        if (conv_done) begin
                            out_hue     <= conv_hue;
                            out_sat     <= conv_sat;
                            out_val     <= conv_val;
                            out_hue_inv <= conv_hue_invalid;
                        end else begin
                            out_hue     <= '0;
                            out_sat     <= '0;
                            out_val     <= '0;
                            out_hue_inv <= 1'b1;
                            if (timeout_cnt != '1) begin
                                timeout_cnt <= timeout_cnt + 1'b1;
                            end
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StEmit: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                        if (out_x == X_LAST) begin
                            x_q <= '0;
                            y_q <= (out_y == Y_LAST) ? '0 : out_y + 1'b1;
                        end else begin
                            x_q <= out_x + 1'b1;
                            y_q <= out_y;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hsv_pixel_sched.sv
// Scoreboard bench: stimulus and converter model push expectations, a monitor checks outputs.
module tb_hsv_pixel_sched;
    import hsv_pkg::*;

    localparam int WIDTH  = 320;
    localparam int HEIGHT = 240;
    localparam int XW     = 9;
    localparam int YW     = 8;
    localparam int TMO    = 32;

    typedef struct packed {
        logic [15:0]   data;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } pend_t;

    typedef struct packed {
        logic          inv;
        logic [6:0]    hue;
        logic [4:0]    sat;
        logic [4:0]    val;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [7:0]    tcnt;
    } exp_t;

    // d = cycles from conv_read to done; negative means the converter never answers.
    typedef struct packed {
        int         d;
        logic       inv;
        logic [6:0] hue;
        logic [4:0] sat;
        logic [4:0] val;
    } plan_t;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          pix_valid = 1'b0;
    logic [15:0]   pix_data = '0;
    logic          pix_sof = 1'b0;
    logic          pix_ready;
    logic          conv_read;
    logic [15:0]   conv_data;
    logic          conv_done = 1'b0;
    logic [6:0]    conv_hue = '0;
    logic          conv_hue_invalid = 1'b0;
    logic [4:0]    conv_sat = '0;
    logic [4:0]    conv_val = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [6:0]    out_hue;
    logic [4:0]    out_sat;
    logic [4:0]    out_val;
    logic          out_hue_inv;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic [7:0]    timeout_cnt;

    hsv_pixel_sched #(
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .XW           (XW),
        .YW           (YW),
        .CONV_TIMEOUT (TMO),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk              (clk),
        .res              (res),
        .pix_valid        (pix_valid),
        .pix_data         (pix_data),
        .pix_sof          (pix_sof),
        .pix_ready        (pix_ready),
        .conv_read        (conv_read),
        .conv_data        (conv_data),
        .conv_done        (conv_done),
        .conv_hue         (conv_hue),
        .conv_hue_invalid (conv_hue_invalid),
        .conv_sat         (conv_sat),
        .conv_val         (conv_val),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_hue          (out_hue),
        .out_sat          (out_sat),
        .out_val          (out_val),
        .out_hue_inv      (out_hue_inv),
        .out_x            (out_x),
        .out_y            (out_y),
        .timeout_cnt      (timeout_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pend_t pend_q[$];
    exp_t  exp_q[$];
    plan_t plan_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int mx = 0, my = 0, m_tcnt = 0;
    int ready_mode = 2;  // 0 random, 1 hold low, 2 hold high
    int acc_cyc = 0, read_cyc = 0, done_cyc = 0, rise_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference coordinate rule: sof restarts the frame, otherwise raster order with wrap.
    task automatic model_accept(input logic [15:0] d, input logic sof);
        pend_t e;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        e.data = d;
        e.x    = XW'(mx);
        e.y    = YW'(my);
        pend_q.push_back(e);
        mx = mx + 1;
        if (mx == WIDTH) begin
            mx = 0;
            my = (my + 1) % HEIGHT;
        end
    endtask

    // Called at a negedge; returns at a negedge with pix_valid low.
    task automatic send_pix(input logic [15:0] d, input logic sof);
        int waited = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        while (!pix_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!pix_ready) begin
            check("send_accept_timeout", 64'(pix_ready), 64'd1);
        end else begin
            acc_cyc = cyc;
            model_accept(d, sof);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((pend_q.size() + exp_q.size()) != 0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 64'(pend_q.size() + exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset(input string name);
        check({name, "_pix_ready"}, 64'(pix_ready), 64'd1);
        check({name, "_conv_read"}, 64'({conv_read, conv_data}), 64'd0);
        check({name, "_out_valid"}, 64'(out_valid), 64'd0);
        check({name, "_out_data"},
              64'({out_hue_inv, out_hue, out_sat, out_val, out_x, out_y}), 64'd0);
        check({name, "_timeout_cnt"}, 64'(timeout_cnt), 64'd0);
    endtask

    function automatic plan_t rand_plan();
        plan_t p;
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 13)      p.d = int'($urandom_range(1, 4));
        else if (r < 16) p.d = int'($urandom_range(30, 34));
        else if (r < 18) p.d = TMO;
        else             p.d = -1;
        p.inv = 1'($urandom);
        p.hue = 7'($urandom);
        p.sat = 5'($urandom);
        p.val = 5'($urandom);
        return p;
    endfunction

    // Converter model: answers each conv_read according to a plan and predicts the result.
    initial begin : conv_model
        int    cnt;
        logic  prev_read;
        plan_t cur;
        pend_t pe;
        exp_t  e;
        cnt       = -1;
        prev_read = 1'b0;
        cur       = '0;
        forever begin
            @(negedge clk);
            conv_done        = 1'b0;
            conv_hue         = 7'($urandom);
            conv_hue_invalid = 1'($urandom);
            conv_sat         = 5'($urandom);
            conv_val         = 5'($urandom);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    conv_done        = 1'b1;
                    conv_hue         = cur.hue;
                    conv_hue_invalid = cur.inv;
                    conv_sat         = cur.sat;
                    conv_val         = cur.val;
                    done_cyc         = cyc;
                    cnt              = -1;
                end
            end
            if (conv_read && !res) begin
                read_cyc = cyc;
                check("conv_read_pulse", 64'(prev_read), 64'd0);
                if (pend_q.size() == 0) begin
                    check("conv_read_unexpected", 64'd1, 64'd0);
                end else begin
                    pe = pend_q.pop_front();
                    check("conv_data", 64'(conv_data), 64'(pe.data));
                    cur = (plan_q.size() != 0) ? plan_q.pop_front() : rand_plan();
                    e.x = pe.x;
                    e.y = pe.y;
                    if (cur.d >= 1 && cur.d <= TMO) begin
                        e.inv = cur.inv;
                        e.hue = cur.hue;
                        e.sat = cur.sat;
                        e.val = cur.val;
                    end else begin
                        e.inv = 1'b1;
                        e.hue = '0;
                        e.sat = '0;
                        e.val = '0;
                        if (m_tcnt < 255) m_tcnt++;
                    end
                    e.tcnt = 8'(m_tcnt);
                    exp_q.push_back(e);
                    cnt = (cur.d >= 1) ? cur.d : -1;
                end
            end
            prev_read = conv_read;
        end
    end

    // Output monitor: drives out_ready, checks hold-while-stalled and pops on each transfer.
    initial begin : monitor
        logic        stall_prev;
        logic        valid_prev;
        logic [63:0] snap;
        exp_t        e;
        stall_prev = 1'b0;
        valid_prev = 1'b0;
        snap       = '0;
        forever begin
            @(negedge clk);
            if (ready_mode == 0)      out_ready = ($urandom_range(0, 3) != 0);
            else if (ready_mode == 1) out_ready = 1'b0;
            else                      out_ready = 1'b1;
            if (res) begin
                stall_prev = 1'b0;
                valid_prev = 1'b0;
                continue;
            end
            if (out_valid && !valid_prev) rise_cyc = cyc;
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({out_hue_inv, out_hue, out_sat, out_val, out_x, out_y,
                                         timeout_cnt}), snap);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_hsv", 64'({out_hue_inv, out_hue, out_sat, out_val}),
                          64'({e.inv, e.hue, e.sat, e.val}));
                    check("out_xy", 64'({out_y, out_x}), 64'({e.y, e.x}));
                    check("out_tcnt", 64'(timeout_cnt), 64'(e.tcnt));
                end
            end
            stall_prev = out_valid && !out_ready;
            snap = 64'({out_hue_inv, out_hue, out_sat, out_val, out_x, out_y, timeout_cnt});
            valid_prev = out_valid;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int    accepts;
        plan_t p;
        repeat (3) @(negedge clk);
        check_reset("reset");
        res = 1'b0;
        @(negedge clk);

        // Single red pixel, converter answers after 9 cycles.
        ready_mode = 2;
        p = '{d: 9, inv: 1'b0, hue: 7'd0, sat: 5'd31, val: 5'd31};
        plan_q.push_back(p);
        send_pix(16'h7C00, 1'b1);
        drain("single");
        check("lat_read", 64'(read_cyc - acc_cyc), 64'd2);
        check("lat_out", 64'(rise_cyc - done_cyc), 64'd1);

        // Timeout with late done, then normal, never-done and done-on-last-cycle cases.
        p = '{d: TMO + 1, inv: 1'b0, hue: 7'd5, sat: 5'd5, val: 5'd5};
        plan_q.push_back(p);
        send_pix(16'h1234, 1'b0);
        drain("timeout");
        check("timeout_cnt_one", 64'(timeout_cnt), 64'd1);
        p = '{d: 5, inv: 1'b0, hue: 7'd77, sat: 5'd9, val: 5'd17};
        plan_q.push_back(p);
        p = '{d: -1, inv: 1'b0, hue: 7'd0, sat: 5'd0, val: 5'd0};
        plan_q.push_back(p);
        p = '{d: TMO, inv: 1'b1, hue: 7'd99, sat: 5'd3, val: 5'd30};
        plan_q.push_back(p);
        for (int i = 0; i < 3; i++) send_pix(16'($urandom_range(0, 32767)), 1'b0);
        drain("after_timeout");
        check("timeout_cnt_two", 64'(timeout_cnt), 64'd2);

        // A little over one line, exercising the x wrap.
        ready_mode = 0;
        for (int i = 0; i < WIDTH + 2; i++) send_pix(16'($urandom_range(0, 32767)), i == 0);
        drain("line_wrap");

        // Output stalled while input keeps offering pixels.
        ready_mode = 1;
        repeat (2) @(negedge clk);
        p = '{d: 3, inv: 1'b0, hue: 7'd42, sat: 5'd21, val: 5'd11};
        plan_q.push_back(p);
        accepts = 0;
        pix_data = 16'($urandom_range(0, 32767));
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'b1;
            if (pix_ready) begin
                model_accept(pix_data, 1'b0);
                accepts++;
                @(negedge clk);
                pix_data = 16'($urandom_range(0, 32767));
            end else begin
                @(negedge clk);
            end
        end
        pix_valid = 1'b0;
        check("stall_ready_low", 64'(pix_ready), 64'd0);
        check("stall_accepts", 64'(accepts), 64'd3);
        ready_mode = 0;
        drain("stall");

        // Start of frame signalled in the middle of a line.
        send_pix(16'h0001, 1'b1);
        for (int i = 1; i < 57; i++) send_pix(16'($urandom_range(0, 32767)), 1'b0);
        send_pix(16'h0ABC, 1'b1);
        send_pix(16'h0DEF, 1'b0);
        drain("mid_sof");

        // Reset while waiting on the converter with the FIFO full.
        ready_mode = 2;
        p = '{d: -1, inv: 1'b0, hue: 7'd0, sat: 5'd0, val: 5'd0};
        plan_q.push_back(p);
        send_pix(16'h2222, 1'b0);
        begin
            int n = 0;
            while (pend_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        send_pix(16'h3333, 1'b0);
        send_pix(16'h4444, 1'b0);
        check("full_before_reset", 64'(pix_ready), 64'd0);
        res = 1'b1;
        @(negedge clk);
        check_reset("mid_reset");
        pend_q.delete();
        exp_q.delete();
        plan_q.delete();
        mx = 0;
        my = 0;
        m_tcnt = 0;
        res = 1'b0;
        @(negedge clk);
        p = '{d: 4, inv: 1'b0, hue: 7'd11, sat: 5'd22, val: 5'd7};
        plan_q.push_back(p);
        send_pix(16'h5555, 1'b0);
        drain("post_reset");

        // Randomised traffic.
        ready_mode = 0;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_pix(16'($urandom_range(0, 32767)), $urandom_range(0, 39) == 0);
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
